xbar_sr_driver: RTL
===================

// Module: xbar_sr_driver
// PURPOSE
//  Parametrised crossbar row/column selector for the PCB control path. It decodes
//  two-byte UART commands into row and column selection masks and serialises them
//  onto N parallel 74HC595-style shift-register chains per axis. Every update ends
//  with a latch pulse. Sits between uart_rx and the board connector, clocked by clk1.
// PARAMETERS
//  N_ROW       32      number of rows (multiple of CH_W, <=64)
//  N_COL       32      number of columns (multiple of CH_W, <=64)
//  CH_W        8       bits per shift-register chain
//  CLK_DIV     4       clk1 cycles per sft_clk/latch_clk half-period (>=1)
//  RX_TIMEOUT  100000  clk1 cycles allowed between byte0 and byte1 of a command
// PORTS
//  clk1          in   1              system clock
//  reset         in   1              synchronous, active-high
//  rx_valid      in   1              1-cycle strobe, rx_data valid
//  rx_data       in   8              received UART byte
//  sft_clk       out  1              shift clock to all chains (data sampled on rise)
//  latch_clk     out  1              storage-register clock (rise transfers)
//  sft_rst_n     out  1              chain clear, active-low
//  oe_n          out  1              output enable, active-low
//  sr_sdi_row    out  N_ROW/CH_W     serial data, one bit per row chain
//  sr_sdi_col    out  N_COL/CH_W     serial data, one bit per column chain
//  busy          out  1              high while shifting or latching
//  cmd_err       out  1              1-cycle pulse on any rejected command
// BEHAVIOUR
//  Reset: all outputs 0 except sft_rst_n=1 and oe_n=1; masks cleared; FSM->INIT.
//  INIT: shift all-zero masks and latch once, then drive oe_n=0 and go to IDLE.
//  Command = byte0 {op[7:6], idx[5:0]=col}, then byte1 {2'b00, idx[5:0]=row}; 0-based.
//   op 00 SET: masks := one-hot(row), one-hot(col) (single cell).
//   op 01 ADD: masks |= one-hot(row), one-hot(col) (multi-cell mode).
//   op 10 CLR: masks := 0; executes after byte0 alone, and byte1 is not expected.
//   op 11 reserved: cmd_err pulse, byte discarded, phase stays at byte0.
//  Reject with a cmd_err pulse (masks unchanged, no shift) when any of these holds:
//   col>=N_COL, row>=N_ROW, byte1[7:6]!=0, or rx_valid while busy (the byte is dropped).
//  Timeout: byte0 held longer than RX_TIMEOUT cycles -> phase resets to byte0 with
//   a cmd_err pulse.
//  Mapping: index i -> chain i/CH_W, bit i%CH_W. Shift bit CH_W-1 first, bit 0 last.
//   All chains shift in parallel.
//  FSM: INIT -> IDLE -> LOAD -> SHIFT_LO <-> SHIFT_HI (CH_W times) -> LATCH -> IDLE.
//   LOAD (1 cycle): capture the new masks into shadow regs, busy=1.
//   SHIFT_LO: sft_clk=0, sdi = current bit, held CLK_DIV cycles.
//   SHIFT_HI: sft_clk=1, sdi stable, held CLK_DIV cycles. Bit counter wraps CH_W-1->0.
//   LATCH: latch_clk=1 for CLK_DIV cycles, then 0. The FSM enters IDLE and busy drops.
//  Latency from the final rx_valid to the latch_clk rise: 1 + 2*CH_W*CLK_DIV cycles.
//  sdi changes only while sft_clk=0. oe_n stays 0 after INIT (outputs keep old value).
//  reset mid-shift: abort immediately, return to reset values, re-run INIT.
//  rx_valid in the same cycle as a timeout expiry: timeout wins and the byte is
//   treated as a new byte0.
// STRUCTURE
//  Package xbar_pkg: state_t enum {INIT,IDLE,LOAD,SHIFT_LO,SHIFT_HI,LATCH}; op_t
//   enum {OP_SET,OP_ADD,OP_CLR,OP_RSV}; function onehot(idx, width).
//  Sub-module sr_piso_bank #(N_CH,CH_W): parallel load, per-chain MSB-first serial out,
//   one instance per axis, sharing the shift-enable strobe from the FSM.
//  Command decode, timeout counter, clock divider and FSM live in the top level.
// TESTING
//  1 Reset release -> INIT shifts zeros: 8 sft_clk rises, 1 latch pulse, then oe_n=0.
//  2 SET col=9,row=3 (bytes 0x09,0x03), CH_W=8 -> sr_sdi_col[1] high on bit 1 only,
//    sr_sdi_row[0] high on bit 3 only; latch after 1+64 cycles (CLK_DIV=4).
//  3 ADD 0x40|5,0x1E after test 2 -> col mask bits 5,9; row mask bits 3,30.
//  4 CLR 0x80 -> a single byte triggers all-zero shift and latch; 0x12 is then byte0.
//  5 Bytes 0x25,0x02 (col 37 with N_COL=32) -> cmd_err pulse, no sft_clk activity.
//  6 Byte0, then a gap of RX_TIMEOUT+1 -> cmd_err; a byte sent during busy -> cmd_err,
//    dropped; reset asserted mid-SHIFT -> outputs at reset values the next cycle.

Source files
------------

// File: rtl/xbar_pkg.sv
// Shared types and helpers for the crossbar shift-register driver.
//   state_t : controller FSM states
//   op_t    : command opcode carried in byte0[7:6]
//   onehot  : index -> 64-bit one-hot vector; all-zero when idx >= width
package xbar_pkg;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    LOAD,
    SHIFT_LO,
    SHIFT_HI,
    LATCH
  } state_t;

  typedef enum logic [1:0] {
    OP_SET = 2'b00,
    OP_ADD = 2'b01,
    OP_CLR = 2'b10,
    OP_RSV = 2'b11
  } op_t;

  localparam int unsigned IDX_W   = 6;
  localparam int unsigned MAX_IDX = 64;

  function automatic logic [MAX_IDX-1:0] onehot(input logic [IDX_W-1:0] idx,
                                                input logic [IDX_W:0]   width);
    logic [MAX_IDX-1:0] v;
    v = '0;
    if ({1'b0, idx} < width) v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/sr_piso_bank.sv
// Bank of N_CH parallel-in / serial-out registers, CH_W bits each.
// Chain c holds data_i[c*CH_W +: CH_W] and presents its MSB on sdo_o[c];
// each shift_i strobe moves the next lower bit into the MSB position.
//   clk1    in   system clock
//   reset   in   synchronous, active-high; clears all chains (sdo_o = 0)
//   load_i  in   capture data_i into the chains
//   shift_i in   shift every chain one place towards the MSB
//   data_i  in   flattened parallel data, chain-major
//   sdo_o   out  serial data, one bit per chain
module sr_piso_bank #(
  parameter int unsigned N_CH = 4,
  parameter int unsigned CH_W = 8
) (
  input  logic                 clk1,
  input  logic                 reset,
  input  logic                 load_i,
  input  logic                 shift_i,
  input  logic [N_CH*CH_W-1:0] data_i,
  output logic [N_CH-1:0]      sdo_o
);

  logic [N_CH-1:0][CH_W-1:0] sr_q, sr_d;

  always_comb begin
    sr_d = sr_q;
    if (load_i) begin
      sr_d = data_i;
    end else if (shift_i) begin
      for (int c = 0; c < int'(N_CH); c++) sr_d[c] = sr_q[c] << 1;
    end
  end

  // The chains drive board pins directly, so they are cleared on reset.
  always_ff @(posedge clk1) begin
    if (reset) sr_q <= '0;
    else       sr_q <= sr_d;
  end

  always_comb begin
    for (int c = 0; c < int'(N_CH); c++) sdo_o[c] = sr_q[c][CH_W-1];
  end

endmodule

// File: rtl/xbar_sr_driver.sv
// Crossbar row/column selector. Decodes two-byte UART commands into row and
// column selection masks and serialises them onto parallel 74HC595-style
// chains (one bank per axis), finishing every update with a latch pulse.
//   clk1        in   system clock
//   reset       in   synchronous, active-high
//   rx_valid    in   1-cycle strobe, rx_data valid
//   rx_data     in   received UART byte
//   sft_clk     out  shift clock to all chains (data sampled on rise)
//   latch_clk   out  storage-register clock (rise transfers)
//   sft_rst_n   out  chain clear, active-low (held inactive)
//   oe_n        out  output enable, active-low; drops after the first latch
//   sr_sdi_row  out  serial data, one bit per row chain
//   sr_sdi_col  out  serial data, one bit per column chain
//   busy        out  high while loading, shifting or latching
//   cmd_err     out  1-cycle pulse on any rejected command
module xbar_sr_driver
  import xbar_pkg::*;
#(
  parameter int unsigned N_ROW      = 32,
  parameter int unsigned N_COL      = 32,
  parameter int unsigned CH_W       = 8,
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned RX_TIMEOUT = 100000
) (
  input  logic                  clk1,
  input  logic                  reset,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  sft_clk,
  output logic                  latch_clk,
  output logic                  sft_rst_n,
  output logic                  oe_n,
  output logic [N_ROW/CH_W-1:0] sr_sdi_row,
  output logic [N_COL/CH_W-1:0] sr_sdi_col,
  output logic                  busy,
  output logic                  cmd_err
);

  localparam int unsigned NR_CH = N_ROW / CH_W;
  localparam int unsigned NC_CH = N_COL / CH_W;
  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BIT_W = (CH_W > 1) ? $clog2(CH_W) : 1;
  localparam int unsigned TMO_W = $clog2(RX_TIMEOUT + 1);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(CH_W - 1);
  localparam logic [TMO_W-1:0] TMO_LIM  = TMO_W'(RX_TIMEOUT);
  localparam logic [IDX_W:0]   N_ROW_L  = N_ROW[IDX_W:0];
  localparam logic [IDX_W:0]   N_COL_L  = N_COL[IDX_W:0];

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic               phase_q, phase_d;     // 0: expecting byte0, 1: expecting byte1
  logic [IDX_W-1:0]   col_q, col_d;
  op_t                op_q, op_d;
  logic [N_ROW-1:0]   row_mask_q, row_mask_d;
  logic [N_COL-1:0]   col_mask_q, col_mask_d;
  logic               sft_clk_q, sft_clk_d;
  logic               latch_clk_q, latch_clk_d;
  logic               oe_n_q, oe_n_d;
  logic               busy_q, busy_d;
  logic               cmd_err_q, cmd_err_d;

  logic               load_en;
  logic               shift_en;
  logic               go;
  logic               expire;
  logic               idle;
  op_t                byte_op;
  logic [IDX_W-1:0]   byte_idx;
  logic [MAX_IDX-1:0] row_oh;
  logic [MAX_IDX-1:0] col_oh;

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    bit_d      = bit_q;
    tmo_d      = tmo_q;
    phase_d    = phase_q;
    col_d      = col_q;
    op_d       = op_q;
    row_mask_d = row_mask_q;
    col_mask_d = col_mask_q;
    oe_n_d     = oe_n_q;
    cmd_err_d  = 1'b0;
    load_en    = 1'b0;
    shift_en   = 1'b0;
    go         = 1'b0;

    byte_op  = op_t'(rx_data[7:6]);
    byte_idx = rx_data[5:0];
    row_oh   = onehot(byte_idx, N_ROW_L);
    col_oh   = onehot(col_q, N_COL_L);
    idle     = (state_q == IDLE);
    // tmo_q counts cycles spent waiting for byte1; reaching the limit
    // abandons the half-received command.
    expire   = phase_q && (tmo_q == TMO_LIM);

    if (phase_q) tmo_d = tmo_q + TMO_W'(1);
    if (expire) begin
      phase_d   = 1'b0;
      tmo_d     = '0;
      cmd_err_d = 1'b1;
    end

    if (rx_valid) begin
      if (!idle) begin
        // Byte arriving during an update is dropped; phase is untouched.
        cmd_err_d = 1'b1;
      end else if (!phase_q || expire) begin
        // A byte coinciding with timeout expiry starts a fresh command.
        case (byte_op)
          OP_SET, OP_ADD: begin
            phase_d = 1'b1;
            tmo_d   = '0;
            op_d    = byte_op;
            col_d   = byte_idx;
          end
          OP_CLR: begin
            row_mask_d = '0;
            col_mask_d = '0;
            go         = 1'b1;
          end
          default: cmd_err_d = 1'b1;
        endcase
      end else begin
        // Column range is checked here so a bad command gives a single pulse.
        phase_d = 1'b0;
        if ((rx_data[7:6] != 2'b00) || ({1'b0, col_q} >= N_COL_L) ||
            ({1'b0, byte_idx} >= N_ROW_L)) begin
          cmd_err_d = 1'b1;
        end else begin
          go = 1'b1;
          if (op_q == OP_SET) begin
            row_mask_d = N_ROW'(row_oh);
            col_mask_d = N_COL'(col_oh);
          end else begin
            row_mask_d = row_mask_q | N_ROW'(row_oh);
            col_mask_d = col_mask_q | N_COL'(col_oh);
          end
        end
      end
    end

    case (state_q)
      // INIT behaves as a LOAD of the cleared masks.
      INIT, LOAD: begin
        load_en = 1'b1;
        div_d   = '0;
        bit_d   = '0;
        state_d = SHIFT_LO;
      end
      IDLE: begin
        if (go) state_d = LOAD;
      end
      SHIFT_LO: begin
        if (div_q == DIV_LAST) begin
          div_d   = '0;
          state_d = SHIFT_HI;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      SHIFT_HI: begin
        if (div_q == DIV_LAST) begin
          div_d    = '0;
          // Advancing the chains on the falling sft_clk keeps sdi stable
          // for the whole high phase.
          shift_en = 1'b1;
          if (bit_q == BIT_LAST) begin
            bit_d   = '0;
            state_d = LATCH;
          end else begin
            bit_d   = bit_q + BIT_W'(1);
            state_d = SHIFT_LO;
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      LATCH: begin
        if (div_q == DIV_LAST) begin
          div_d   = '0;
          state_d = IDLE;
          oe_n_d  = 1'b0;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      default: state_d = INIT;
    endcase

    // Outputs are registered from the next state so they are glitch-free
    // and line up with the state they belong to.
    sft_clk_d   = (state_d == SHIFT_HI);
    latch_clk_d = (state_d == LATCH);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk1) begin
    if (reset) begin
      state_q     <= INIT;
      div_q       <= '0;
      bit_q       <= '0;
      tmo_q       <= '0;
      phase_q     <= 1'b0;
      col_q       <= '0;
      op_q        <= OP_SET;
      row_mask_q  <= '0;
      col_mask_q  <= '0;
      sft_clk_q   <= 1'b0;
      latch_clk_q <= 1'b0;
      oe_n_q      <= 1'b1;
      busy_q      <= 1'b0;
      cmd_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      bit_q       <= bit_d;
      tmo_q       <= tmo_d;
      phase_q     <= phase_d;
      col_q       <= col_d;
      op_q        <= op_d;
      row_mask_q  <= row_mask_d;
      col_mask_q  <= col_mask_d;
      sft_clk_q   <= sft_clk_d;
      latch_clk_q <= latch_clk_d;
      oe_n_q      <= oe_n_d;
      busy_q      <= busy_d;
      cmd_err_q   <= cmd_err_d;
    end
  end

  sr_piso_bank #(
    .N_CH (NR_CH),
    .CH_W (CH_W)
  ) u_row_bank (
    .clk1    (clk1),
    .reset   (reset),
    .load_i  (load_en),
    .shift_i (shift_en),
    .data_i  (row_mask_q),
    .sdo_o   (sr_sdi_row)
  );

  sr_piso_bank #(
    .N_CH (NC_CH),
    .CH_W (CH_W)
  ) u_col_bank (
    .clk1    (clk1),
    .reset   (reset),
    .load_i  (load_en),
    .shift_i (shift_en),
    .data_i  (col_mask_q),
    .sdo_o   (sr_sdi_col)
  );

  // Chains are always cleared by shifting zeros in INIT, so the hardware
  // clear is never exercised.
  assign sft_rst_n = 1'b1;
  assign sft_clk   = sft_clk_q;
  assign latch_clk = latch_clk_q;
  assign oe_n      = oe_n_q;
  assign busy      = busy_q;
  assign cmd_err   = cmd_err_q;

endmodule
